// File: rtl/soc_sysid_regs.sv
// soc_sysid_regs: system-identification register block on an Avalon-MM slave port.
// Fixed ID, build timestamp and capability word, plus software scratch words.
// Optional feature macro: SYSID_UPTIME_EN adds a 64-bit free-running uptime
// counter with an atomic LO/HI split read (hi_snap) and a CTRL.freeze bit.
// Without the macro, words 3..5 read 0, ignore writes, and CAPS[0] is 0.
module soc_sysid_regs #(
  parameter logic [31:0] ID_VALUE    = 32'hC0503000,
  parameter logic [31:0] TIMESTAMP   = 32'd1766243476,
  parameter int unsigned NUM_SCRATCH = 2,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  // Register map, word addresses
  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TSTAMP  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CAPS    = ADDR_W'(2);
`ifdef SYSID_UPTIME_EN
  localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(5);
  localparam logic              UPTIME_PRESENT = 1'b1;
`else
  localparam logic              UPTIME_PRESENT = 1'b0;
`endif
  localparam int unsigned       SCR_BASE  = 8;

  localparam logic [7:0]  CAPS_VERSION = 8'h02;
  localparam logic [31:0] CAPS_VALUE   =
    {CAPS_VERSION, 8'(NUM_SCRATCH), 15'b0, UPTIME_PRESENT};

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Scratch registers
  // ---------------------------------------------------------------------------
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];

  // Scratch next-state: byte-lane merge on a write to the matching word
  always_comb begin
    scratch_d = scratch_q;
    for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
      if (write && (address == ADDR_W'(SCR_BASE + i))) begin
        scratch_d[i] = byte_merge(scratch_q[i], writedata, byteenable);
      end
    end
  end

  // Scratch state register
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      scratch_q <= scratch_d;
    end
  end

`ifdef SYSID_UPTIME_EN
  // ---------------------------------------------------------------------------
  // Uptime counter, HI snapshot and freeze control
  // ---------------------------------------------------------------------------
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        freeze_q, freeze_d;
  logic        wr_lo, wr_hi, wr_ctrl, rd_lo;

  assign wr_lo   = write && (address == A_UP_LO);
  assign wr_hi   = write && (address == A_UP_HI);
  assign wr_ctrl = write && (address == A_CTRL);
  assign rd_lo   = read  && (address == A_UP_LO);

  // Counter next-state: a preload of either half suppresses the increment
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) cnt_d[31:0]  = byte_merge(cnt_q[31:0],  writedata, byteenable);
      if (wr_hi) cnt_d[63:32] = byte_merge(cnt_q[63:32], writedata, byteenable);
    end else if (!freeze_q) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Snapshot and freeze next-state; snapshot takes the live HI seen by the LO read
  always_comb begin
    snap_d   = snap_q;
    freeze_d = freeze_q;
    if (rd_lo) snap_d = cnt_q[63:32];
    if (wr_ctrl && byteenable[0]) freeze_d = writedata[0];
  end

  // Uptime state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      snap_q   <= '0;
      freeze_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      freeze_q <= freeze_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;

  // Read mux over the current (pre-write) register state
  always_comb begin
    rdata_d = '0;
    case (address)
      A_ID:     rdata_d = ID_VALUE;
      A_TSTAMP: rdata_d = TIMESTAMP;
      A_CAPS:   rdata_d = CAPS_VALUE;
`ifdef SYSID_UPTIME_EN
      A_UP_LO:  rdata_d = cnt_q[31:0];
      A_UP_HI:  rdata_d = snap_q;
      A_CTRL:   rdata_d = {31'b0, freeze_q};
`endif
      default: begin
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
          if (address == ADDR_W'(SCR_BASE + i)) rdata_d = scratch_q[i];
        end
      end
    endcase
  end

  // Response register: fixed one-cycle latency, data held until the next read
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= read;
      if (read) rdata_q <= rdata_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: doc/soc_sysid_regs.md
# soc_sysid_regs

Parametrised system-identification register block for the SoC, the next generation of the fixed two-word sysid slave. It answers an Avalon-MM slave port with a fixed ID, a build timestamp and a capability word. It also provides a 64-bit free-running uptime counter with an atomic split read, and a small bank of scratch registers for software bring-up. It sits on the system interconnect next to the other peripheral slaves, and drivers poll it at boot.

## Interface
Parameters:
- ID_VALUE, 32'hC0503000, constant returned at word 0
- TIMESTAMP, 32'd1766243476, build timestamp returned at word 1
- NUM_SCRATCH, 2, number of R/W scratch words (legal range 1..8)
- ADDR_W, 4, word-address width (must be ≥4)

Ports:
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_W  word address
- read  in  1  read strobe, single cycle per access
- write  in  1  write strobe
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes
- readdata  out  32  registered read data
- readdatavalid  out  1  high for exactly one cycle per accepted read

## Operation
- Register map (word address):
  - 0: ID_VALUE (RO)
  - 1: TIMESTAMP (RO)
  - 2: CAPS (RO) = {8'h02 version, NUM_SCRATCH[7:0], 15'b0, uptime_present}
  - 3: UPTIME_LO (RW)
  - 4: UPTIME_HI (RW)
  - 5: CTRL (RW), bit0 = freeze, other bits read 0
  - 8..8+NUM_SCRATCH-1: SCRATCH[i] (RW)
- Unmapped addresses read 0; writes to them, and to RO words, are ignored.
- Writes honour byteenable per byte lane (scratch, UPTIME_LO/HI, CTRL byte 0).
- Uptime counter: 64 bits, +1 every clock while freeze=0, wraps 2^64-1 → 0; holds while freeze=1.
- Reading UPTIME_LO returns counter[31:0] as sampled in the read cycle. In the same cycle, counter[63:32] is latched into hi_snap.
- Reading UPTIME_HI returns hi_snap, not the live counter.
- Writing UPTIME_LO or UPTIME_HI preloads the addressed half of the live counter with the enabled bytes. There is no increment in that cycle, and the other half is unchanged. hi_snap is not modified.
- read and write asserted together are both serviced. readdata returns the pre-write value.

## Timing
- Reset values: readdata=0, readdatavalid=0, counter=0, hi_snap=0, freeze=0, all scratch=0.
- Read latency is fixed at 1. A read in cycle N gives readdatavalid=1 and readdata in cycle N+1.
- readdata holds its value until the next read. readdatavalid is 0 in every cycle not following a read.
- Back-to-back reads are accepted every cycle, with no waitrequest.
- A write takes effect at the clock edge ending the write cycle and is visible to a read in the next cycle.
- A read in the same cycle as a counter preload returns the pre-preload value.
- If reset is asserted during an access, the response is cancelled: readdatavalid=0 in the following cycle.

## Configuration
- SYSID_UPTIME_EN defined: the uptime counter, hi_snap, CTRL.freeze and UPTIME_LO/HI are implemented as above, and CAPS[0]=1.
- SYSID_UPTIME_EN undefined: no counter logic is generated. Words 3, 4 and 5 read 0 and writes to them are ignored. CAPS[0]=0. All other behaviour is identical.

## Test plan
- Release reset, then read words 0, 1, 2 back-to-back → readdatavalid on 3 consecutive cycles with 32'hC0503000, 32'd1766243476, 32'h02020001 (defaults).
- Write 32'hDEADBEEF to SCRATCH0 with byteenable=4'b0101, then read it → 32'h00AD00EF. Then read word 7 → 0.
- Preload UPTIME_HI=32'h00000001, UPTIME_LO=32'hFFFFFFFE. Read LO one cycle later → 32'hFFFFFFFF. Read HI two cycles later → 32'h00000001 (snapshot, despite carry into live HI).
- Write CTRL=1, wait 10 cycles, and read UPTIME_LO twice → identical values. Write CTRL=0 → the counter resumes.
- Read and write SCRATCH1 in the same cycle with writedata=32'h12345678 → readdata is the old value, and a following read returns 32'h12345678.
- Build without SYSID_UPTIME_EN → CAPS=32'h02020000, and words 3 to 5 read 0 after writes.
